// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath.
// The sequencer uses the slave modport; the datapath (or a bench) uses the master one.
interface multicycle_ctrl_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       RegWrite;
  logic       illegal;
  logic [3:0] state_o;

  modport slave (
    input  op, funct3, funct7, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, illegal, state_o
  );

  modport master (
    output op, funct3, funct7, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, illegal, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Moore sequencer for the multi-cycle RV32I core: fetch/decode/execute/memory/writeback
// with memory stalls on mem_ready. Handshake: an access completes in the cycle mem_ready=1.
module multicycle_ctrl_fsm (
  input  logic                         clk,
  input  logic                         rst,
  multicycle_ctrl_fsm_if.slave         bus
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [3:0] state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update, branch;
  logic       ir_write, reg_write, mem_write, illegal_raw;
  logic       adr_src;
  logic [1:0] result_src, src_a, src_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    alu_op      = 2'b00;
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    illegal_raw = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    src_a       = 2'b00;
    src_b       = 2'b00;
    case (state_q)
      S_FETCH: begin
        src_b      = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.mem_ready;
        pc_update  = bus.mem_ready;
        state_d    = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        // Strobe stays up across the whole stall so the memory sees a stable request.
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        src_a   = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        src_a  = 2'b10;
        alu_op = 2'b01;
        branch = 1'b1;
      end
      S_JAL: begin
        src_a     = 2'b01;
        src_b     = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.ALUControl = 3'b000;
    case (alu_op)
      2'b01: bus.ALUControl = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  bus.ALUControl = (bus.op[5] & bus.funct7[5]) ? 3'b001 : 3'b000;
          3'b010:  bus.ALUControl = 3'b101;
          3'b110:  bus.ALUControl = 3'b011;
          3'b111:  bus.ALUControl = 3'b010;
          default: bus.ALUControl = 3'b000;
        endcase
      end
      default: bus.ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_BEQ:  bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

  // Strobes are gated by rst so they drop in the same instant reset asserts.
  assign bus.PCWrite   = rst & (pc_update | (branch & bus.zero));
  assign bus.IRWrite   = rst & ir_write;
  assign bus.RegWrite  = rst & reg_write;
  assign bus.MemWrite  = rst & mem_write;
  assign bus.illegal   = rst & illegal_raw;
  assign bus.AdrSrc    = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = src_a;
  assign bus.ALUSrcB   = src_b;
  assign bus.state_o   = state_q;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: one table row per clock cycle, plus a
// hand sequence for reset asserted in the middle of a jal.
module tb_multicycle_ctrl_fsm;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b0000000;
  localparam logic [6:0] F_ADD  = 7'b0000000;
  localparam logic [6:0] F_SUB  = 7'b0100000;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        zero;
    logic        rdy;
    logic [20:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  vec_t vecs[$];
  int   n_cmp;
  int   n_err;

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {state, PCWrite, IRWrite, RegWrite, MemWrite, illegal, AdrSrc, ALUControl, ImmSrc, ResultSrc, ALUSrcA, ALUSrcB}
  function automatic logic [20:0] actual();
    return {bus.state_o, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite,
            bus.illegal, bus.AdrSrc, bus.ALUControl, bus.ImmSrc, bus.ResultSrc,
            bus.ALUSrcA, bus.ALUSrcB};
  endfunction

  task automatic add_v(input int r, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input int z, input int rdy,
                       input int st, input int pcw, input int irw, input int rgw,
                       input int mw, input int ill, input int adr, input int alu,
                       input int imm, input int res, input int sa, input int sb);
    vec_t v;
    v.rst  = r[0];
    v.op   = op;
    v.f3   = f3;
    v.f7   = f7;
    v.zero = z[0];
    v.rdy  = rdy[0];
    v.exp  = {st[3:0], pcw[0], irw[0], rgw[0], mw[0], ill[0], adr[0],
              alu[2:0], imm[1:0], res[1:0], sa[1:0], sb[1:0]};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst           = v.rst;
    bus.op        = v.op;
    bus.funct3    = v.f3;
    bus.funct7    = v.f7;
    bus.zero      = v.zero;
    bus.mem_ready = v.rdy;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus.op = OP_R; bus.funct3 = 3'b000; bus.funct7 = F_ADD;
    bus.zero = 1'b0; bus.mem_ready = 1'b1;

    //    rst op      f3      f7    z rdy st pcw irw rgw mw ill adr alu imm res sa sb
    add_v(0, OP_R,   3'b000, F_ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2);
    // add x3,x1,x2
    add_v(1, OP_R,   3'b000, F_ADD, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 2);
    add_v(1, OP_R,   3'b000, F_ADD, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add_v(1, OP_R,   3'b000, F_ADD, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    add_v(1, OP_R,   3'b000, F_ADD, 0, 1, 8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // sub
    add_v(1, OP_R,   3'b000, F_SUB, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 2);
    add_v(1, OP_R,   3'b000, F_SUB, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add_v(1, OP_R,   3'b000, F_SUB, 0, 1, 6, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0);
    add_v(1, OP_R,   3'b000, F_SUB, 0, 1, 8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // slt: execute only
    add_v(1, OP_R,   3'b010, F_ADD, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 2);
    add_v(1, OP_R,   3'b010, F_ADD, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add_v(1, OP_R,   3'b010, F_ADD, 0, 1, 6, 0, 0, 0, 0, 0, 0, 5, 0, 0, 2, 0);
    add_v(1, OP_R,   3'b010, F_ADD, 0, 1, 8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // addi with funct7-looking bits set: op[5]=0 keeps it an add
    add_v(1, OP_I,   3'b000, F_SUB, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 2);
    add_v(1, OP_I,   3'b000, F_SUB, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add_v(1, OP_I,   3'b000, F_SUB, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
    add_v(1, OP_I,   3'b000, F_SUB, 0, 1, 8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // andi then ori
    add_v(1, OP_I,   3'b111, F_ADD, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 2);
    add_v(1, OP_I,   3'b111, F_ADD, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add_v(1, OP_I,   3'b111, F_ADD, 0, 1, 7, 0, 0, 0, 0, 0, 0, 2, 0, 0, 2, 1);
    add_v(1, OP_I,   3'b111, F_ADD, 0, 1, 8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add_v(1, OP_I,   3'b110, F_ADD, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 2);
    add_v(1, OP_I,   3'b110, F_ADD, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add_v(1, OP_I,   3'b110, F_ADD, 0, 1, 7, 0, 0, 0, 0, 0, 0, 3, 0, 0, 2, 1);
    add_v(1, OP_I,   3'b110, F_ADD, 0, 1, 8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // lw with 2 fetch stalls and 3 memread stalls
    add_v(1, OP_LW,  3'b010, F_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2);
    add_v(1, OP_LW,  3'b010, F_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2);
    add_v(1, OP_LW,  3'b010, F_ADD, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 2);
    add_v(1, OP_LW,  3'b010, F_ADD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add_v(1, OP_LW,  3'b010, F_ADD, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
    add_v(1, OP_LW,  3'b010, F_ADD, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_v(1, OP_LW,  3'b010, F_ADD, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_v(1, OP_LW,  3'b010, F_ADD, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_v(1, OP_LW,  3'b010, F_ADD, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_v(1, OP_LW,  3'b010, F_ADD, 0, 1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    // sw with 2 memwrite stalls
    add_v(1, OP_SW,  3'b010, F_ADD, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 2, 0, 2);
    add_v(1, OP_SW,  3'b010, F_ADD, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    add_v(1, OP_SW,  3'b010, F_ADD, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1);
    add_v(1, OP_SW,  3'b010, F_ADD, 0, 0, 5, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    add_v(1, OP_SW,  3'b010, F_ADD, 0, 0, 5, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    add_v(1, OP_SW,  3'b010, F_ADD, 0, 1, 5, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    // beq taken (zero high in decode must not write PC)
    add_v(1, OP_BEQ, 3'b000, F_ADD, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 2, 2, 0, 2);
    add_v(1, OP_BEQ, 3'b000, F_ADD, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1);
    add_v(1, OP_BEQ, 3'b000, F_ADD, 1, 1, 9, 1, 0, 0, 0, 0, 0, 1, 2, 0, 2, 0);
    // beq not taken
    add_v(1, OP_BEQ, 3'b000, F_ADD, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 2, 2, 0, 2);
    add_v(1, OP_BEQ, 3'b000, F_ADD, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1);
    add_v(1, OP_BEQ, 3'b000, F_ADD, 0, 1, 9, 0, 0, 0, 0, 0, 0, 1, 2, 0, 2, 0);
    // unsupported opcode
    add_v(1, OP_BAD, 3'b000, F_ADD, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 2);
    add_v(1, OP_BAD, 3'b000, F_ADD, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
    // jal
    add_v(1, OP_JAL, 3'b000, F_ADD, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 3, 2, 0, 2);
    add_v(1, OP_JAL, 3'b000, F_ADD, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 1);
    add_v(1, OP_JAL, 3'b000, F_ADD, 0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 2);
    add_v(1, OP_JAL, 3'b000, F_ADD, 0, 1, 8, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), actual(), vecs[i].exp);
    end

    // Reset asserted while in JAL: strobes and state must drop at once.
    @(posedge clk);
    #1;
    check("jal_back_to_fetch", {17'd0, bus.state_o}, 21'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("jal_state", {17'd0, bus.state_o}, 21'd10);
    check("jal_pcwrite", {20'd0, bus.PCWrite}, 21'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_jal_state", {17'd0, bus.state_o}, 21'd0);
    check("rst_mid_jal_pcwrite", {20'd0, bus.PCWrite}, 21'd0);
    check("rst_mid_jal_irwrite", {20'd0, bus.IRWrite}, 21'd0);
    @(negedge clk);
    check("rst_hold_outputs", actual(), {4'd0, 6'b000000, 3'd0, 2'd3, 2'd2, 2'd0, 2'd2});
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_fetch", actual(), {4'd0, 6'b110000, 3'd0, 2'd3, 2'd2, 2'd0, 2'd2});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Moore-style sequencer for the multi-cycle RV32I datapath. One shared memory, one ALU, and IR/PC/OldPC/Data/ALUOut registers.
- Steps each instruction through fetch/decode/execute/memory/writeback states.
- Issues per-cycle mux selects, write strobes and ALU operation codes.
- Stalls on memory accesses until the memory handshake completes.
- Replaces the single-cycle control path in the multi-cycle core top.

Parameters:
- none (ISA subset fixed: lw, sw, R-type, I-type ALU, beq, jal)

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25]; only bit 5 used.
- zero  in  1  ALU zero flag, same cycle.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address: 0=PC, 1=Result.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR and OldPC enable.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 reg.
- ALUSrcB  out  2  00=rs2 reg, 01=ImmExt, 10=const 4.
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- RegWrite  out  1  register file write enable.
- illegal  out  1  one-cycle pulse on unsupported opcode.
- state_o  out  4  current state code, for debug.

Behaviour:
- State register: 4 bits. Async clear to FETCH on rst=0.
- While rst=0:
  - PCWrite, IRWrite, RegWrite, MemWrite and illegal are forced 0.
  - The other outputs show their FETCH values: AdrSrc=0, ResultSrc=10, ALUSrcA=00, ALUSrcB=10, ALUControl=000, state_o=0.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11-15 go to FETCH on the next edge.
- Signals not listed for a state are 0.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=mem_ready, PCUpdate=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target). Next state by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BEQ.
  - 1101111 -> JAL.
  - any other op -> FETCH with illegal=1 for this cycle.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Stay while mem_ready=0, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite held for every stall cycle. Stay while mem_ready=0, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next ALUWB, which writes PC+4 to rd.
- PCWrite = PCUpdate | (Branch & zero). Combinational; zero is sampled in the same cycle.
- ImmSrc is combinational from op:
  - 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; all others -> 00.
- ALUControl is combinational from ALUOp, op, funct3 and funct7[5]:
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10, funct3 000: 001 if op[5]&funct7[5], else 000.
  - ALUOp 10, funct3 010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000.
- Latencies with mem_ready tied 1 (cycles from FETCH entry back to FETCH):
  - lw 5, sw 4, R/I 4, beq 3, jal 4.
- Reset asserted mid-instruction: state returns to FETCH immediately. No strobe may glitch high after rst falls.

Test Plan:
- Reset, then rst=1, mem_ready=1, IR add x3,x1,x2 (op 0110011, f3 000, f7 0000000): states 0,1,6,8,0; ALUControl=000 in EXECR; RegWrite=1 only in ALUWB.
- sub (f7 0100000) via EXECR -> ALUControl=001. addi with f7 bits=0100000 via EXECI -> ALUControl=000, because op[5]=0.
- lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD:
  - IRWrite and PCWrite pulse exactly once, on the ready cycle.
  - States 0,0,0,1,2,3,3,3,3,4,0; RegWrite=1 with ResultSrc=01 in MEMWB.
- sw: ImmSrc=01; MemWrite=1 with AdrSrc=1 through every MEMWRITE cycle until mem_ready; RegWrite never 1.
- beq in BEQ state:
  - zero=1 -> PCWrite=1, ALUControl=001.
  - zero=0 -> PCWrite=0; state returns to 0 after 3 cycles total.
- Opcode 0000000 -> illegal=1 for one cycle in DECODE, back to FETCH. Then jal: states 0,1,10,8,0 with PCWrite=1 in JAL and ImmSrc=11. Assert rst=0 mid-JAL: state_o=0 and PCWrite=0 immediately.
